// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: command opcodes and FSM states.
package counter_sched_pkg;

  localparam int unsigned CMD_OP_W = 2;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_START  = 2'b00,
    CMD_STOP   = 2'b01,
    CMD_LOAD   = 2'b10,
    CMD_SETCMP = 2'b11
  } cmd_op_e;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/counter_sched_if.sv
// Host-facing command and event handshake bundle for counter_sched.
interface counter_sched_if
  import counter_sched_pkg::*;
#(
  parameter int unsigned W = 64
);

  logic         cmd_valid;
  logic         cmd_ready;
  cmd_op_e      cmd_op;
  logic [W-1:0] cmd_data;
  logic         evt_valid;
  logic         evt_ready;
  logic         evt_overrun;

  modport master (
    output cmd_valid, cmd_op, cmd_data, evt_ready,
    input  cmd_ready, evt_valid, evt_overrun
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, evt_ready,
    output cmd_ready, evt_valid, evt_overrun
  );

endinterface

// File: rtl/counter_dp.sv
// W-bit registered up-counter; load beats clear beats increment.
module counter_dp #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (ld)     count <= ld_val;
    else if (clr)    count <= '0;
    else if (inc_en) count <= count + W'(1);
  end

endmodule

// File: rtl/counter_sched.sv
// Command-driven scheduler around counter_dp: FSM, compare register,
// match event reporting with overrun detection, and both handshakes.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            periodic,
  output logic [W-1:0]    count,
  output logic            running,
  counter_sched_if.slave  bus
);

  state_e       state, state_n;
  logic [W-1:0] cmp;
  logic         evt_valid_q, evt_valid_n;
  logic         evt_overrun_q, evt_overrun_n;
  logic         cmd_ready_q, cmd_ready_n;
  logic         dp_ld, dp_clr, dp_inc;

  logic cmd_acc, start_acc, stop_acc, load_acc, setcmp_acc, match;

  assign cmd_acc    = bus.cmd_valid && cmd_ready_q;
  assign start_acc  = cmd_acc && (bus.cmd_op == CMD_START);
  assign stop_acc   = cmd_acc && (bus.cmd_op == CMD_STOP);
  assign load_acc   = cmd_acc && (bus.cmd_op == CMD_LOAD);
  assign setcmp_acc = cmd_acc && (bus.cmd_op == CMD_SETCMP);
  assign match      = (state == S_RUN) && (count == cmp);

  counter_dp #(.W(W)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (dp_inc),
    .clr    (dp_clr),
    .ld     (dp_ld),
    .ld_val (bus.cmd_data),
    .count  (count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state: an accepted STOP outranks a one-shot expiry
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_acc) state_n = S_RUN;
      S_RUN: begin
        if (stop_acc)                  state_n = S_IDLE;
        else if (match && !periodic)   state_n = S_DONE;
      end
      S_DONE:  if (start_acc) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    dp_ld  = load_acc;
    dp_clr = ((state == S_DONE) && start_acc) || (match && periodic && !stop_acc);
    dp_inc = (state == S_RUN) && !match && !stop_acc;

    evt_valid_n = evt_valid_q;
    if (evt_valid_q && bus.evt_ready) evt_valid_n = 1'b0;
    if (match)                        evt_valid_n = 1'b1;

    evt_overrun_n = evt_overrun_q;
    if (start_acc)                                  evt_overrun_n = 1'b0;
    if (match && evt_valid_q && !bus.evt_ready)     evt_overrun_n = 1'b1;

    // A one-shot expiry blocks new commands until the host acks it
    cmd_ready_n = !((state_n == S_DONE) && evt_valid_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp           <= '0;
      evt_valid_q   <= 1'b0;
      evt_overrun_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      running       <= 1'b0;
    end else begin
      if (setcmp_acc) cmp <= bus.cmd_data;
      evt_valid_q   <= evt_valid_n;
      evt_overrun_q <= evt_overrun_n;
      cmd_ready_q   <= cmd_ready_n;
      running       <= (state_n == S_RUN);
    end
  end

  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_overrun = evt_overrun_q;
  assign bus.cmd_ready   = cmd_ready_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed scoreboard bench for counter_sched: events are predicted into a
// queue by the stimulus thread and consumed by an independent monitor.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] ALL1 = '1;

  typedef struct {
    logic [W-1:0] cnt;
    logic         run;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         periodic;
  logic [W-1:0] count;
  logic         running;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic evt_prev;

  counter_sched_if #(.W(W)) bus ();

  counter_sched #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .periodic (periodic),
    .count    (count),
    .running  (running),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input cmd_op_e op, input logic [W-1:0] d);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: op %0d never accepted at %0t", op, $time);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ack_evt();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic push_evt(input logic [W-1:0] c, input logic r);
    exp_t e;
    e.cnt = c;
    e.run = r;
    sb.push_back(e);
  endtask

  // Monitor: every rising evt_valid consumes one predicted event
  always @(negedge clk) begin
    if (bus.evt_valid && !evt_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: event with count %0h, none expected at %0t", count, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_count", count, mon_e.cnt);
        chk("evt_running", W'(running), W'(mon_e.run));
      end
    end
    evt_prev <= bus.evt_valid;
  end

  initial begin
    evt_prev      = 1'b0;
    rst_n         = 1'b1;
    periodic      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = CMD_START;
    bus.cmd_data  = '0;
    bus.evt_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("rst_count", count, '0);
    chk("rst_running", W'(running), '0);
    chk("rst_evt_valid", W'(bus.evt_valid), '0);
    chk("rst_overrun", W'(bus.evt_overrun), '0);
    chk("rst_cmd_ready", W'(bus.cmd_ready), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", W'(bus.cmd_ready), W'(1));

    // 1: one-shot, cmp=5
    send(CMD_SETCMP, W'(5));
    send(CMD_START, '0);
    chk("t1_count0", count, '0);
    chk("t1_running", W'(running), W'(1));
    push_evt(W'(5), 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t1_count", count, W'(i));
    end
    chk("t1_evt_not_yet", W'(bus.evt_valid), '0);
    @(negedge clk);
    chk("t1_evt_valid", W'(bus.evt_valid), W'(1));
    chk("t1_done_running", W'(running), '0);
    chk("t1_done_cmd_ready", W'(bus.cmd_ready), '0);
    repeat (3) @(negedge clk);
    chk("t1_hold_count", count, W'(5));
    chk("t1_hold_cmd_ready", W'(bus.cmd_ready), '0);
    ack_evt();
    chk("t1_ack_evt", W'(bus.evt_valid), '0);
    chk("t1_ack_cmd_ready", W'(bus.cmd_ready), W'(1));

    // 2: periodic, cmp=3, evt_ready held high
    periodic      = 1'b1;
    bus.evt_ready = 1'b1;
    send(CMD_SETCMP, W'(3));
    push_evt('0, 1'b1);
    push_evt('0, 1'b1);
    send(CMD_START, '0);
    for (int k = 0; k < 10; k++) begin
      chk("t2_count", count, W'(k % 4));
      @(negedge clk);
    end
    chk("t2_overrun", W'(bus.evt_overrun), '0);
    send(CMD_STOP, '0);
    chk("t2_stop_count", count, W'(2));
    chk("t2_stop_running", W'(running), '0);
    bus.evt_ready = 1'b0;

    // 3: periodic, cmp=2, no acks -> overrun; START clears it
    send(CMD_LOAD, '0);
    send(CMD_SETCMP, W'(2));
    push_evt('0, 1'b1);
    send(CMD_START, '0);
    repeat (4) @(negedge clk);
    chk("t3_first_evt", W'(bus.evt_valid), W'(1));
    chk("t3_no_overrun_yet", W'(bus.evt_overrun), '0);
    repeat (2) @(negedge clk);
    chk("t3_overrun_set", W'(bus.evt_overrun), W'(1));
    send(CMD_STOP, '0);
    chk("t3_overrun_sticky", W'(bus.evt_overrun), W'(1));
    send(CMD_START, '0);
    chk("t3_overrun_cleared", W'(bus.evt_overrun), '0);
    chk("t3_restart_count", count, '0);
    send(CMD_STOP, '0);
    ack_evt();
    chk("t3_acked", W'(bus.evt_valid), '0);

    // 4: silent wrap, one-shot match at 1
    periodic = 1'b0;
    send(CMD_LOAD, ALL1 - W'(1));
    send(CMD_SETCMP, W'(1));
    push_evt(W'(1), 1'b0);
    send(CMD_START, '0);
    chk("t4_count_m2", count, ALL1 - W'(1));
    @(negedge clk);
    chk("t4_count_m1", count, ALL1);
    @(negedge clk);
    chk("t4_count_wrap", count, '0);
    @(negedge clk);
    chk("t4_count_1", count, W'(1));
    @(negedge clk);
    chk("t4_done_running", W'(running), '0);
    chk("t4_done_cmd_ready", W'(bus.cmd_ready), '0);
    ack_evt();

    // 5: STOP in the match cycle
    send(CMD_SETCMP, W'(4));
    send(CMD_START, '0);
    repeat (4) @(negedge clk);
    chk("t5_at_cmp", count, W'(4));
    push_evt(W'(4), 1'b0);
    send(CMD_STOP, '0);
    chk("t5_evt_valid", W'(bus.evt_valid), W'(1));
    chk("t5_count_held", count, W'(4));
    chk("t5_idle_cmd_ready", W'(bus.cmd_ready), W'(1));
    ack_evt();

    // 6: async reset mid-run
    send(CMD_SETCMP, W'(100));
    send(CMD_LOAD, '0);
    send(CMD_START, '0);
    repeat (7) @(negedge clk);
    chk("t6_count7", count, W'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", count, '0);
    chk("t6_rst_running", W'(running), '0);
    chk("t6_rst_evt", W'(bus.evt_valid), '0);
    chk("t6_rst_cmd_ready", W'(bus.cmd_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_post_count", count, '0);
    chk("t6_post_running", W'(running), '0);
    chk("t6_post_evt", W'(bus.evt_valid), '0);

    chk("sb_empty", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
